// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared definitions for the register-bank port master: default widths, the
// write-sequence increment and the FSM state encoding.
// ---------------------------------------------------------------------------
package br_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int STEP_DEF   = 100;

    // FSM state encoding, kept as plain constants so legacy code can compare
    // against raw state values.
    typedef logic [2:0] br_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WRITE   = 3'd1;
    localparam logic [2:0] ST_RD_ADDR = 3'd2;
    localparam logic [2:0] ST_RD_CAP  = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/br_port_master.sv
// ---------------------------------------------------------------------------
// br_port_master
// Initiator for a register bank. On start it writes registers 1..nregs with
// base, base+STEP, base+2*STEP, ... and then reads them back two at a time,
// presenting each pair on a valid/ready result channel.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base, nregs  sequence request; base/nregs latched on start in IDLE
//   busy, done          busy while sequencing, one-cycle done pulse at end
//   we, aw, dataIn      bank write port
//   ar1, ar2, dr1, dr2  bank read ports (dr* combinational from ar*)
//   res_valid/ready     result handshake
//   res_a, res_b        data of odd / even register of the pair (res_b 0 if
//                       the pair has no even register)
//   res_idx             odd register address of the pair
// All outputs are registered.
// ---------------------------------------------------------------------------
module br_port_master
    import br_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int STEP   = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [ADDR_W-1:0] nregs,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [ADDR_W-1:0] aw,
    output logic [DATA_W-1:0] dataIn,
    output logic [ADDR_W-1:0] ar1,
    output logic [ADDR_W-1:0] ar2,
    input  logic [DATA_W-1:0] dr1,
    input  logic [DATA_W-1:0] dr2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_a,
    output logic [DATA_W-1:0] res_b,
    output logic [ADDR_W-1:0] res_idx
);

    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

    br_state_t         state_r;
    // Shared register index: write index i during WRITE, pair index k during
    // read-back. One extra bit so k+2 past the last register never wraps.
    logic [ADDR_W:0]   cnt_r;
    logic [ADDR_W-1:0] nregs_r;
    // Latched base, advanced by STEP with every write so it always holds the
    // value currently on dataIn; the next value needs only one adder.
    logic [DATA_W-1:0] base_r;

    logic [ADDR_W:0]   cnt_inc_s;
    logic [ADDR_W:0]   k_next_s;
    logic [ADDR_W:0]   n_ext_s;
    logic [DATA_W-1:0] wr_next_s;
    logic              last_s;

    // Second read address of a pair: zero when k is the final register.
    function automatic logic [ADDR_W-1:0] pair_ar2(input logic [ADDR_W:0]   k,
                                                   input logic [ADDR_W-1:0] n);
        logic [ADDR_W:0] k1;
        k1 = k + (ADDR_W+1)'(1);
        if (k == {1'b0, n}) begin
            return '0;
        end else begin
            return k1[ADDR_W-1:0];
        end
    endfunction

    // Counter/data arithmetic shared by the FSM branches.
    always_comb begin
        n_ext_s   = {1'b0, nregs_r};
        cnt_inc_s = cnt_r + (ADDR_W+1)'(1);
        k_next_s  = cnt_r + (ADDR_W+1)'(2);
        wr_next_s = base_r + STEP_V;
        last_s    = (cnt_r == n_ext_s);
    end

    // Sequencer FSM with all bank and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            nregs_r   <= '0;
            base_r    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            we        <= 1'b0;
            aw        <= '0;
            dataIn    <= '0;
            ar1       <= '0;
            ar2       <= '0;
            res_valid <= 1'b0;
            res_a     <= '0;
            res_b     <= '0;
            res_idx   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r  <= base;
                        nregs_r <= nregs;
                        if (nregs == '0) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            // First write is presented the cycle after start.
                            state_r <= ST_WRITE;
                            busy    <= 1'b1;
                            cnt_r   <= (ADDR_W+1)'(1);
                            we      <= 1'b1;
                            aw      <= ADDR_W'(1);
                            dataIn  <= base;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WRITE: begin
                    if (last_s) begin
                        state_r <= ST_RD_ADDR;
                        we      <= 1'b0;
                        cnt_r   <= (ADDR_W+1)'(1);
                        ar1     <= ADDR_W'(1);
                        ar2     <= pair_ar2((ADDR_W+1)'(1), nregs_r);
                    end else begin
                        cnt_r  <= cnt_inc_s;
                        aw     <= cnt_inc_s[ADDR_W-1:0];
                        base_r <= wr_next_s;
                        dataIn <= wr_next_s;
                    end
                end

                ST_RD_ADDR: begin
                    // Addresses are on the bank; read data settles this cycle.
                    state_r <= ST_RD_CAP;
                end

                ST_RD_CAP: begin
                    state_r   <= ST_OUT;
                    res_a     <= dr1;
                    res_b     <= last_s ? '0 : dr2;
                    res_idx   <= cnt_r[ADDR_W-1:0];
                    res_valid <= 1'b1;
                end

                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cnt_r     <= k_next_s;
                        if (k_next_s > n_ext_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_RD_ADDR;
                            ar1     <= k_next_s[ADDR_W-1:0];
                            ar2     <= pair_ar2(k_next_s, nregs_r);
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not sampled here.
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end

                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    we        <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br_port_master.sv
// ---------------------------------------------------------------------------
// tb_br_port_master
// Directed bench: br_port_master driving a behavioural 32x32 register bank.
// ---------------------------------------------------------------------------
module tb_br_port_master;
    import br_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] base = '0;
    logic [AW-1:0] nregs = '0;
    logic          res_ready = 1'b1;
    logic          busy, done, we, res_valid;
    logic [AW-1:0] aw, ar1, ar2, res_idx;
    logic [DW-1:0] dataIn, dr1, dr2, res_a, res_b;

    int n_tests = 0;
    int n_fail  = 0;

    br_port_master #(.DATA_W(DW), .ADDR_W(AW), .STEP(100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .nregs(nregs),
        .busy(busy), .done(done), .we(we), .aw(aw), .dataIn(dataIn),
        .ar1(ar1), .ar2(ar2), .dr1(dr1), .dr2(dr2),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_a(res_a), .res_b(res_b), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    // Register bank: register 0 reads as zero and is never written.
    logic [DW-1:0] bank_mem [32];
    initial for (int i = 0; i < 32; i++) bank_mem[i] = '0;
    always @(posedge clk) if (we && aw != '0) bank_mem[aw] <= dataIn;
    assign dr1 = (ar1 == '0) ? '0 : bank_mem[ar1];
    assign dr2 = (ar2 == '0) ? '0 : bank_mem[ar2];

    // Transaction logs.
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [AW-1:0] rs_idx_q[$];
    logic [DW-1:0] rs_a_q[$];
    logic [DW-1:0] rs_b_q[$];
    logic [AW-1:0] rs_ar2_q[$];
    int            valid_seen = 0;

    always @(posedge clk) begin
        if (we) begin
            wr_addr_q.push_back(aw);
            wr_data_q.push_back(dataIn);
        end
        if (res_valid) valid_seen++;
        if (res_valid && res_ready) begin
            rs_idx_q.push_back(res_idx);
            rs_a_q.push_back(res_a);
            rs_b_q.push_back(res_b);
            rs_ar2_q.push_back(ar2);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete();
        rs_idx_q.delete(); rs_a_q.delete(); rs_b_q.delete(); rs_ar2_q.delete();
        valid_seen = 0;
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic start_seq(input logic [DW-1:0] b, input logic [AW-1:0] n);
        @(negedge clk);
        base = b; nregs = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts clock edges until done is seen, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    // Reference model of the write stream and the result pairs.
    task automatic verify(input string tag, input logic [DW-1:0] b, input int n);
        int np;
        int k;
        logic [31:0] ea, eb;
        np = (n + 1) / 2;
        check({tag, "_wr_cnt"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_aw"}, 32'(wr_addr_q[i]), 32'(i + 1));
            check({tag, "_din"}, wr_data_q[i], b + 32'(i) * 32'd100);
        end
        check({tag, "_res_cnt"}, 32'(rs_idx_q.size()), 32'(np));
        for (int j = 0; j < np && j < rs_idx_q.size(); j++) begin
            k  = 2 * j + 1;
            ea = b + 32'(k - 1) * 32'd100;
            eb = (k < n) ? b + 32'(k) * 32'd100 : 32'd0;
            check({tag, "_idx"}, 32'(rs_idx_q[j]), 32'(k));
            check({tag, "_res_a"}, rs_a_q[j], ea);
            check({tag, "_res_b"}, rs_b_q[j], eb);
            check({tag, "_ar2"}, 32'(rs_ar2_q[j]), (k < n) ? 32'(k + 1) : 32'd0);
        end
    endtask

    initial begin
        int e;
        int w;
        logic [DW-1:0] ha, hb;
        logic [AW-1:0] hi;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_din", dataIn, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: base=100, nregs=4; latency = n + 3*ceil(n/2) edges after start
        clear_logs();
        start_seq(32'd100, 5'd4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_we_first", 32'(we), 32'd1);
        wait_done(e);
        check("t1_latency", 32'(e), 32'd10);
        verify("t1", 32'd100, 4);
        check("t1_r4", bank_mem[4], 32'd400);
        check("t1_pair2_b", rs_b_q[1], 32'd400);
        check("t1_busy_done", 32'(busy), 32'd0);
        start = 1'b1;               // start during DONE must be ignored
        @(negedge clk);
        start = 1'b0;
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_start_in_done", 32'(busy), 32'd0);
        check("t1_no_extra_wr", 32'(wr_addr_q.size()), 32'd4);

        // 2: base=7, nregs=3 -> (1,7,107), (3,207,0)
        clear_logs();
        start_seq(32'd7, 5'd3);
        wait_done(e);
        check("t2_latency", 32'(e), 32'd9);
        verify("t2", 32'd7, 3);
        check("t2_a2", rs_a_q[1], 32'd207);
        check("t2_b2", rs_b_q[1], 32'd0);
        check("t2_ar2", 32'(rs_ar2_q[1]), 32'd0);
        @(negedge clk);

        // 3: nregs=0 -> done next cycle, no write, no result
        clear_logs();
        start_seq(32'd55, 5'd0);
        wait_done(e);
        check("t3_latency", 32'(e), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t3_no_we", 32'(wr_addr_q.size()), 32'd0);
        check("t3_no_valid", 32'(valid_seen), 32'd0);

        // 4: back-pressure for 5 cycles in OUT
        clear_logs();
        res_ready = 1'b0;
        start_seq(32'd11, 5'd2);
        w = 0;
        while (!res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("t4_valid", 32'(res_valid), 32'd1);
        ha = res_a; hb = res_b; hi = res_idx;
        check("t4_a", ha, 32'd11);
        check("t4_b", hb, 32'd111);
        check("t4_idx", 32'(hi), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(res_valid), 32'd1);
            check("t4_hold_a", res_a, ha);
            check("t4_hold_b", res_b, hb);
            check("t4_hold_idx", 32'(res_idx), 32'(hi));
            check("t4_no_done", 32'(done), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t4_valid_drop", 32'(res_valid), 32'd0);
        wait_done(e);
        verify("t4", 32'd11, 2);
        @(negedge clk);

        // 5: wrap of the write value; start during WRITE ignored
        clear_logs();
        start_seq(32'hFFFF_FFC0, 5'd2);
        base = 32'h0000_1234; nregs = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e);
        verify("t5", 32'hFFFF_FFC0, 2);
        check("t5_r2_wrap", bank_mem[2], 32'h0000_0024);
        @(negedge clk);

        // 6: asynchronous reset in the middle of WRITE, then a clean rerun
        clear_logs();
        start_seq(32'd1000, 5'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we", 32'(we), 32'd0);
        check("t6_aw", 32'(aw), 32'd0);
        check("t6_din", dataIn, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        start_seq(32'd7, 5'd3);
        wait_done(e);
        check("t6_latency", 32'(e), 32'd9);
        verify("t6", 32'd7, 3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
